commit_agg_sched: RTL and testbench

- In-order commit scheduler for the MPU. Holds a circular table of outstanding instructions, one entry per issued instruction: valid bit, issue number, enabled-TPU bitmap and commit bitmap.
- Each TPU reports commits independently. The block marks them in the table.
- It retires the oldest entry once every enabled TPU has committed. Sits between the MPU issue stage and the TPU array commit outputs.

---
 rtl/commit_agg_sched_if.sv | 29 ++
 rtl/commit_agg_sched.sv | 144 ++++++++++++++
 tb/tb_commit_agg_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_agg_sched_if.sv
// Issue/commit bundle between the MPU issue stage, the TPU array and commit_agg_sched.
// The master drives requests and commit reports; the slave is the scheduler.
interface commit_agg_sched_if #(
    parameter int NUM_TPU     = 4,
    parameter int WIDTH_ISSUE = 8
);
    logic                           I_Req_Issue;
    logic [WIDTH_ISSUE-1:0]         I_Issue_No;
    logic [NUM_TPU-1:0]             I_En_TPU;
    logic                           O_Full;
    logic                           O_Empty;
    logic [NUM_TPU-1:0]             I_Commit;
    logic [NUM_TPU*WIDTH_ISSUE-1:0] I_Commit_No;
    logic                           O_Commit;
    logic [WIDTH_ISSUE-1:0]         O_Commit_No;
    logic                           O_Err;
    logic                           O_Timeout;
    logic [NUM_TPU-1:0]             O_Timeout_Mask;

    modport master (
        output I_Req_Issue, I_Issue_No, I_En_TPU, I_Commit, I_Commit_No,
        input  O_Full, O_Empty, O_Commit, O_Commit_No, O_Err, O_Timeout, O_Timeout_Mask
    );

    modport slave (
        input  I_Req_Issue, I_Issue_No, I_En_TPU, I_Commit, I_Commit_No,
        output O_Full, O_Empty, O_Commit, O_Commit_No, O_Err, O_Timeout, O_Timeout_Mask
    );
endinterface

// File: rtl/commit_agg_sched.sv
// In-order commit scheduler: gathers per-TPU commits per issued instruction and retires the oldest.
// Optional head-entry watchdog enabled by defining COMMIT_AGG_TIMEOUT_EN.
module commit_agg_sched #(
    parameter int NUM_ENTRY      = 4,
    parameter int NUM_TPU        = 4,
    parameter int WIDTH_ISSUE    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clock,
    input logic               reset,
    commit_agg_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_ENTRY);
    localparam int CW = $clog2(NUM_ENTRY) + 1;

    logic                   ent_v  [NUM_ENTRY];
    logic [WIDTH_ISSUE-1:0] ent_no [NUM_ENTRY];
    logic [NUM_TPU-1:0]     ent_en [NUM_ENTRY];
    logic [NUM_TPU-1:0]     ent_cm [NUM_ENTRY];
    logic [NUM_TPU-1:0]     new_cm [NUM_ENTRY];

    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               dup_hit;
    logic               issue_ok;
    logic               issue_err;
    logic [NUM_TPU-1:0] tpu_hit;
    logic               commit_err;
    logic               retire;

    assign full        = (count == CW'(NUM_ENTRY));
    assign bus.O_Full  = full;
    assign bus.O_Empty = (count == '0);

    always_comb begin
        dup_hit = 1'b0;
        for (int e = 0; e < NUM_ENTRY; e++) begin
            if (ent_v[e] && (ent_no[e] == bus.I_Issue_No)) dup_hit = 1'b1;
        end
    end

    // Full check ignores a same-cycle retire so the MPU only ever has to watch O_Full.
    assign issue_ok  = bus.I_Req_Issue && !full && !dup_hit;
    assign issue_err = bus.I_Req_Issue && !full && dup_hit;

    // Issue numbers are unique among valid entries, so each commit matches at most one entry.
    always_comb begin
        tpu_hit    = '0;
        commit_err = 1'b0;
        for (int e = 0; e < NUM_ENTRY; e++) new_cm[e] = ent_cm[e];
        for (int t = 0; t < NUM_TPU; t++) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                if (bus.I_Commit[t] && ent_v[e] && ent_en[e][t] &&
                    (ent_no[e] == bus.I_Commit_No[t*WIDTH_ISSUE +: WIDTH_ISSUE])) begin
                    new_cm[e][t] = 1'b1;
                    tpu_hit[t]   = 1'b1;
                end
            end
            if (bus.I_Commit[t] && !tpu_hit[t]) commit_err = 1'b1;
        end
    end

    assign retire = ent_v[rptr] && (new_cm[rptr] == ent_en[rptr]);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                ent_v[e]  <= 1'b0;
                ent_no[e] <= '0;
                ent_en[e] <= '0;
                ent_cm[e] <= '0;
            end
            wptr            <= '0;
            rptr            <= '0;
            count           <= '0;
            bus.O_Commit    <= 1'b0;
            bus.O_Commit_No <= '0;
            bus.O_Err       <= 1'b0;
        end else begin
            // A free slot at wptr is never the head being retired, so the two cases cannot collide.
            for (int e = 0; e < NUM_ENTRY; e++) begin
                if (retire && (rptr == PW'(e))) begin
                    ent_v[e]  <= 1'b0;
                    ent_no[e] <= '0;
                    ent_en[e] <= '0;
                    ent_cm[e] <= '0;
                end else if (issue_ok && (wptr == PW'(e))) begin
                    ent_v[e]  <= 1'b1;
                    ent_no[e] <= bus.I_Issue_No;
                    ent_en[e] <= bus.I_En_TPU;
                    ent_cm[e] <= '0;
                end else begin
                    ent_cm[e] <= new_cm[e];
                end
            end

            if (issue_ok) wptr <= wptr + PW'(1);
            if (retire) begin
                rptr            <= rptr + PW'(1);
                bus.O_Commit_No <= ent_no[rptr];
            end
            bus.O_Commit <= retire;
            bus.O_Err    <= issue_err || commit_err;

            case ({issue_ok, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef COMMIT_AGG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt;

    // Watchdog only reports a stuck head; the entry stays so a late commit can still retire it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt            <= '0;
            bus.O_Timeout      <= 1'b0;
            bus.O_Timeout_Mask <= '0;
        end else begin
            bus.O_Timeout <= 1'b0;
            if (!ent_v[rptr] || retire) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_cnt            <= '0;
                bus.O_Timeout      <= 1'b1;
                bus.O_Timeout_Mask <= ent_en[rptr] & ~new_cm[rptr];
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end
`else
    assign bus.O_Timeout      = 1'b0;
    assign bus.O_Timeout_Mask = '0;
`endif

endmodule

// File: tb/tb_commit_agg_sched.sv
// Self-checking bench for commit_agg_sched: directed vector table, reset/timeout sequences,
// and randomized traffic against a queue-based reference of the in-order commit table.
module tb_commit_agg_sched;
    localparam int NE = 4;
    localparam int NT = 4;
    localparam int WI = 8;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    commit_agg_sched_if #(.NUM_TPU(NT), .WIDTH_ISSUE(WI)) bus ();

    commit_agg_sched #(
        .NUM_ENTRY(NE), .NUM_TPU(NT), .WIDTH_ISSUE(WI), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Reference: the table as an ordered queue, head at index 0.
    typedef struct {
        logic [WI-1:0] no;
        logic [NT-1:0] en;
        logic [NT-1:0] cm;
    } ent_t;

    ent_t          mq[$];
    logic          m_commit;
    logic [WI-1:0] m_no;
    logic          m_err;

    function automatic void model_step(logic req, logic [WI-1:0] no, logic [NT-1:0] en,
                                       logic [NT-1:0] cm, logic [NT*WI-1:0] cno);
        int n    = mq.size();
        bit dup  = 1'b0;
        m_err    = 1'b0;
        m_commit = 1'b0;
        foreach (mq[i]) if (mq[i].no == no) dup = 1'b1;
        for (int t = 0; t < NT; t++) begin
            if (cm[t]) begin
                bit hit = 1'b0;
                foreach (mq[i]) begin
                    if (mq[i].no == cno[t*WI +: WI] && mq[i].en[t]) begin
                        mq[i].cm[t] = 1'b1;
                        hit = 1'b1;
                    end
                end
                if (!hit) m_err = 1'b1;
            end
        end
        if (n > 0 && mq[0].cm == mq[0].en) begin
            m_commit = 1'b1;
            m_no     = mq[0].no;
            void'(mq.pop_front());
        end
        if (req && n < NE) begin
            if (dup) m_err = 1'b1;
            else     mq.push_back('{no, en, '0});
        end
    endfunction

    task automatic applyStimulus(input logic req, input logic [WI-1:0] no, input logic [NT-1:0] en,
                                 input logic [NT-1:0] cm, input logic [NT*WI-1:0] cno);
        bus.I_Req_Issue = req;
        bus.I_Issue_No  = no;
        bus.I_En_TPU    = en;
        bus.I_Commit    = cm;
        bus.I_Commit_No = cno;
        model_step(req, no, en, cm, cno);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, '0, '0);
        reset = 1'b1;
        mq.delete();
    endtask

    typedef struct {
        string         name;
        logic          req;
        logic [WI-1:0] no;
        logic [NT-1:0] en;
        logic [NT-1:0] cm;
        logic [31:0]   cno;
        logic          e_commit;
        logic [WI-1:0] e_no;
        logic          e_err;
        logic          e_full;
        logic          e_empty;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cycles;
        int seen;

        // name, req, no, en, commit, commit_no, exp commit, exp no, exp err, exp full, exp empty
        vecs.push_back('{"issue05",     1, 8'h05, 4'b0011, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"c0_05",       0, 8'h00, 4'b0000, 4'b0001, 32'h00000005, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"c1_05",       0, 8'h00, 4'b0000, 4'b0010, 32'h00000500, 1, 8'h05, 0, 0, 1});
        vecs.push_back('{"idleA",       0, 8'h00, 4'b0000, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 1});
        vecs.push_back('{"issue01",     1, 8'h01, 4'b1111, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"issue02",     1, 8'h02, 4'b1111, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"issue03",     1, 8'h03, 4'b1111, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"issue04",     1, 8'h04, 4'b1111, 4'b0000, 32'h00000000, 0, 8'h00, 0, 1, 0});
        vecs.push_back('{"issue05full", 1, 8'h05, 4'b1111, 4'b0000, 32'h00000000, 0, 8'h00, 0, 1, 0});
        vecs.push_back('{"call02",      0, 8'h00, 4'b0000, 4'b1111, 32'h02020202, 0, 8'h00, 0, 1, 0});
        vecs.push_back('{"call01",      0, 8'h00, 4'b0000, 4'b1111, 32'h01010101, 1, 8'h01, 0, 0, 0});
        vecs.push_back('{"ret02",       0, 8'h00, 4'b0000, 4'b0000, 32'h00000000, 1, 8'h02, 0, 0, 0});
        vecs.push_back('{"call03",      0, 8'h00, 4'b0000, 4'b1111, 32'h03030303, 1, 8'h03, 0, 0, 0});
        vecs.push_back('{"call04",      0, 8'h00, 4'b0000, 4'b1111, 32'h04040404, 1, 8'h04, 0, 0, 1});
        vecs.push_back('{"issue10",     1, 8'h10, 4'b0101, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"issue11",     1, 8'h11, 4'b1010, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"cmix",        0, 8'h00, 4'b0000, 4'b1111, 32'h11101110, 1, 8'h10, 0, 0, 0});
        vecs.push_back('{"ret11",       0, 8'h00, 4'b0000, 4'b0000, 32'h00000000, 1, 8'h11, 0, 0, 1});
        vecs.push_back('{"c2_33",       0, 8'h00, 4'b0000, 4'b0100, 32'h00330000, 0, 8'h00, 1, 0, 1});
        vecs.push_back('{"errclr",      0, 8'h00, 4'b0000, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 1});
        vecs.push_back('{"issue10b",    1, 8'h10, 4'b0001, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"dup10",       1, 8'h10, 4'b0001, 4'b0000, 32'h00000000, 0, 8'h00, 1, 0, 0});
        vecs.push_back('{"duperrclr",   0, 8'h00, 4'b0000, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"c0_10",       0, 8'h00, 4'b0000, 4'b0001, 32'h00000010, 1, 8'h10, 0, 0, 1});
        vecs.push_back('{"issue20en0",  1, 8'h20, 4'b0000, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"ret20",       0, 8'h00, 4'b0000, 4'b0000, 32'h00000000, 1, 8'h20, 0, 0, 1});
        vecs.push_back('{"samecyc21",   1, 8'h21, 4'b0001, 4'b0001, 32'h00000021, 0, 8'h00, 1, 0, 0});
        vecs.push_back('{"issue22",     1, 8'h22, 4'b0001, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{"issue23",     1, 8'h23, 4'b0001, 4'b0000, 32'h00000000, 0, 8'h00, 0, 0, 0});

        $display("[TB] start");
        reset = 1'b1;
        doReset();
        checkOutput("rst_empty",  32'(bus.O_Empty), 32'd1);
        checkOutput("rst_full",   32'(bus.O_Full), 32'd0);
        checkOutput("rst_commit", 32'(bus.O_Commit), 32'd0);
        checkOutput("rst_no",     32'(bus.O_Commit_No), 32'd0);
        checkOutput("rst_err",    32'(bus.O_Err), 32'd0);
        checkOutput("rst_tmo",    32'(bus.O_Timeout), 32'd0);
        checkOutput("rst_mask",   32'(bus.O_Timeout_Mask), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].no, vecs[i].en, vecs[i].cm, vecs[i].cno);
            checkOutput({vecs[i].name, "_commit"}, 32'(bus.O_Commit), 32'(vecs[i].e_commit));
            if (vecs[i].e_commit)
                checkOutput({vecs[i].name, "_no"}, 32'(bus.O_Commit_No), 32'(vecs[i].e_no));
            checkOutput({vecs[i].name, "_err"},   32'(bus.O_Err), 32'(vecs[i].e_err));
            checkOutput({vecs[i].name, "_full"},  32'(bus.O_Full), 32'(vecs[i].e_full));
            checkOutput({vecs[i].name, "_empty"}, 32'(bus.O_Empty), 32'(vecs[i].e_empty));
        end

        // Reset with three entries pending, while a commit that would retire the head arrives.
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, 4'b0001, 32'h00000021);
        checkOutput("midrst_commit", 32'(bus.O_Commit), 32'd0);
        checkOutput("midrst_empty",  32'(bus.O_Empty), 32'd1);
        reset = 1'b1;
        mq.delete();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, '0, '0);
            if (bus.O_Commit) seen++;
        end
        checkOutput("postrst_nocommit", 32'(seen), 32'd0);
        checkOutput("postrst_empty",    32'(bus.O_Empty), 32'd1);
        applyStimulus(1'b0, '0, '0, 4'b0001, 32'h00000021);
        checkOutput("postrst_stale_err", 32'(bus.O_Err), 32'd1);
        checkOutput("postrst_stale_nocommit", 32'(bus.O_Commit), 32'd0);

        // Watchdog on a head entry that only TPU0 ever commits.
        doReset();
        applyStimulus(1'b1, 8'h40, 4'b1111, '0, '0);
        applyStimulus(1'b0, '0, '0, 4'b0001, 32'h00000040);
        cycles = 1;
`ifdef COMMIT_AGG_TIMEOUT_EN
        while (!bus.O_Timeout && cycles < 40) begin
            applyStimulus(1'b0, '0, '0, '0, '0);
            cycles++;
        end
        checkOutput("tmo_pulse",   32'(bus.O_Timeout), 32'd1);
        checkOutput("tmo_latency", 32'(cycles), 32'd16);
        checkOutput("tmo_mask",    32'(bus.O_Timeout_Mask), 32'h0000000e);
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("tmo_oneshot", 32'(bus.O_Timeout), 32'd0);
        checkOutput("tmo_kept",    32'(bus.O_Empty), 32'd0);
`else
        seen = 0;
        while (cycles < 40) begin
            applyStimulus(1'b0, '0, '0, '0, '0);
            if (bus.O_Timeout || (bus.O_Timeout_Mask != '0)) seen++;
            cycles++;
        end
        checkOutput("tmo_off", 32'(seen), 32'd0);
        checkOutput("tmo_kept", 32'(bus.O_Empty), 32'd0);
`endif

        // Randomized traffic against the queue reference.
        doReset();
        for (int k = 0; k < 600; k++) begin
            logic          r_req;
            logic [WI-1:0] r_no;
            logic [NT-1:0] r_en;
            logic [NT-1:0] r_cm;
            logic [31:0]   r_cno;
            r_req = 1'($urandom_range(0, 1));
            r_no  = 8'($urandom_range(0, 7));
            r_en  = 4'($urandom_range(0, 15));
            r_cm  = '0;
            r_cno = '0;
            for (int t = 0; t < NT; t++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r_cm[t] = 1'b1;
                    if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                        int idx = int'($urandom_range(0, mq.size() - 1));
                        r_cno[t*WI +: WI] = mq[idx].no;
                    end else begin
                        r_cno[t*WI +: WI] = 8'($urandom_range(0, 15));
                    end
                end
            end
            applyStimulus(r_req, r_no, r_en, r_cm, r_cno);
            checkOutput("rnd_commit", 32'(bus.O_Commit), 32'(m_commit));
            if (m_commit) checkOutput("rnd_no", 32'(bus.O_Commit_No), 32'(m_no));
            checkOutput("rnd_err",   32'(bus.O_Err), 32'(m_err));
            checkOutput("rnd_full",  32'(bus.O_Full), 32'(mq.size() == NE));
            checkOutput("rnd_empty", 32'(bus.O_Empty), 32'(mq.size() == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
